// File: rtl/instructie_sequencer_pkg.sv
// Shared ISA definitions for the instructie sequencer: opcodes, ALU operation codes,
// FSM state encoding and the opcode decode record produced by the opcode LUT.
package instructie_sequencer_pkg;

  localparam logic [7:0] OPC_ADD_RR = 8'h01;
  localparam logic [7:0] OPC_ADD_RI = 8'h21;
  localparam logic [7:0] OPC_SUB_RR = 8'h02;
  localparam logic [7:0] OPC_SUB_RI = 8'h22;
  localparam logic [7:0] OPC_XOR    = 8'h03;
  localparam logic [7:0] OPC_OR     = 8'h04;
  localparam logic [7:0] OPC_AND    = 8'h05;
  localparam logic [7:0] OPC_NOT    = 8'h06;

  localparam logic [5:0] ALU_ADD = 6'b001000;
  localparam logic [5:0] ALU_SUB = 6'b010000;
  localparam logic [5:0] ALU_XOR = 6'b100000;
  localparam logic [5:0] ALU_OR  = 6'b000010;
  localparam logic [5:0] ALU_AND = 6'b000100;
  localparam logic [5:0] ALU_NOT = 6'b000001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_A,
    ST_LATCH_A,
    ST_READ_B,
    ST_LATCH_B,
    ST_EXEC,
    ST_WRITE,
    ST_DONE
  } seq_state_e;

  typedef struct packed {
    logic [5:0] alu_op;
    logic       uses_imm;
    logic       single_operand;
    logic       legal;
  } opc_decode_t;

  function automatic opc_decode_t make_decode(input logic [5:0] op, input logic imm,
                                              input logic single);
    opc_decode_t d;
    d.alu_op         = op;
    d.uses_imm       = imm;
    d.single_operand = single;
    d.legal          = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/instructie_sequencer_lut.sv
// Combinational opcode decoder: maps an opcode to its ALU operation and operand shape.
// Unknown opcodes decode to all-zero, i.e. legal=0.
module instructie_opcode_lut
  import instructie_sequencer_pkg::*;
#(
  parameter int OPC_W = 8
) (
  input  logic [OPC_W-1:0] opcode_i,
  output opc_decode_t      decode_o
);

  always_comb begin
    decode_o = '0;
    case (opcode_i)
      OPC_W'(OPC_ADD_RR): decode_o = make_decode(ALU_ADD, 1'b0, 1'b0);
      OPC_W'(OPC_ADD_RI): decode_o = make_decode(ALU_ADD, 1'b1, 1'b0);
      OPC_W'(OPC_SUB_RR): decode_o = make_decode(ALU_SUB, 1'b0, 1'b0);
      OPC_W'(OPC_SUB_RI): decode_o = make_decode(ALU_SUB, 1'b1, 1'b0);
      OPC_W'(OPC_XOR):    decode_o = make_decode(ALU_XOR, 1'b0, 1'b0);
      OPC_W'(OPC_OR):     decode_o = make_decode(ALU_OR,  1'b0, 1'b0);
      OPC_W'(OPC_AND):    decode_o = make_decode(ALU_AND, 1'b0, 1'b0);
      OPC_W'(OPC_NOT):    decode_o = make_decode(ALU_NOT, 1'b0, 1'b1);
      default:            decode_o = '0;
    endcase
  end

endmodule

// File: rtl/instructie_sequencer.sv
// Sequencer that runs one ALU instruction at a time: read operands, execute, write back, pulse done.
// Optional zero_flag output is enabled by defining SEQ_ZERO_FLAG_EN.
module instructie_sequencer
  import instructie_sequencer_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int OPC_W   = 8,
  parameter int ALUOP_W = 6
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [OPC_W-1:0]   instructie,
  input  logic [DATA_W-1:0]  argument1,
  input  logic [DATA_W-1:0]  argument2,
  output logic               done,
  output logic               illegal,
  output logic               rf_ce,
  output logic               rf_we,
  output logic [ADDR_W-1:0]  rf_addr,
  output logic [DATA_W-1:0]  rf_wdata,
  input  logic [DATA_W-1:0]  rf_rdata,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [ALUOP_W-1:0] alu_op,
  input  logic [DATA_W-1:0]  alu_result
`ifdef SEQ_ZERO_FLAG_EN
  ,
  output logic               zero_flag
`endif
);

  seq_state_e         state_q, state_d;
  opc_decode_t        dec;
  logic [ADDR_W-1:0]  arg_a_q;
  logic [DATA_W-1:0]  arg2_q;
  logic               use_imm_q, single_q, illegal_q;
  logic [DATA_W-1:0]  alu_a_q, alu_b_q, wdata_q;
  logic [ALUOP_W-1:0] alu_op_q;
  logic               unused_arg1_bits;

  assign unused_arg1_bits = ^argument1[DATA_W-1:ADDR_W];

  instructie_opcode_lut #(.OPC_W(OPC_W)) u_lut (
    .opcode_i (instructie),
    .decode_o (dec)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Register file strobes are decoded from state so reset drops them immediately.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    rf_ce       = 1'b0;
    rf_we       = 1'b0;
    rf_addr     = '0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = dec.legal ? ST_READ_A : ST_DONE;
      end
      ST_READ_A: begin
        rf_ce   = 1'b1;
        rf_addr = arg_a_q;
        state_d = ST_LATCH_A;
      end
      ST_LATCH_A: state_d = (use_imm_q || single_q) ? ST_EXEC : ST_READ_B;
      ST_READ_B: begin
        rf_ce   = 1'b1;
        rf_addr = arg2_q[ADDR_W-1:0];
        state_d = ST_LATCH_B;
      end
      ST_LATCH_B: state_d = ST_EXEC;
      ST_EXEC:    state_d = ST_WRITE;
      ST_WRITE: begin
        rf_ce   = 1'b1;
        rf_we   = 1'b1;
        rf_addr = arg_a_q;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        illegal = illegal_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      arg_a_q   <= '0;
      arg2_q    <= '0;
      use_imm_q <= 1'b0;
      single_q  <= 1'b0;
      illegal_q <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      wdata_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            arg_a_q   <= argument1[ADDR_W-1:0];
            arg2_q    <= argument2;
            use_imm_q <= dec.uses_imm;
            single_q  <= dec.single_operand;
            illegal_q <= ~dec.legal;
            if (dec.legal) alu_op_q <= ALUOP_W'(dec.alu_op);
          end
        end
        ST_LATCH_A: begin
          alu_a_q <= rf_rdata;
          if (single_q)       alu_b_q <= '0;
          else if (use_imm_q) alu_b_q <= arg2_q;
        end
        ST_LATCH_B: alu_b_q <= rf_rdata;
        ST_EXEC:    wdata_q <= alu_result;
        default: ;
      endcase
    end
  end

`ifdef SEQ_ZERO_FLAG_EN
  logic zero_q;

  // Only legal instructions reach WRITE, so illegal ones leave the flag untouched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                 zero_q <= 1'b0;
    else if (state_q == ST_WRITE) zero_q <= (wdata_q == '0);
  end

  assign zero_flag = zero_q;
`endif

  assign rf_wdata = wdata_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;

endmodule

// File: tb/tb_instructie_sequencer.sv
// Scoreboard bench for instructie_sequencer with a behavioural register file and ALU.
module tb_instructie_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instructie;
  logic [15:0] argument1, argument2;
  logic        done, illegal, rf_ce, rf_we;
  logic [3:0]  rf_addr;
  logic [15:0] rf_wdata, rf_rdata, alu_a, alu_b, alu_result;
  logic [5:0]  alu_op;
`ifdef SEQ_ZERO_FLAG_EN
  logic        zero_flag;
`endif

  always #5 clock = ~clock;

  instructie_sequencer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instructie  (instructie),
    .argument1   (argument1),
    .argument2   (argument2),
    .done        (done),
    .illegal     (illegal),
    .rf_ce       (rf_ce),
    .rf_we       (rf_we),
    .rf_addr     (rf_addr),
    .rf_wdata    (rf_wdata),
    .rf_rdata    (rf_rdata),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result)
`ifdef SEQ_ZERO_FLAG_EN
    ,
    .zero_flag   (zero_flag)
`endif
  );

  typedef struct {
    logic        ill;
    int          lat;
    int          acc;
    int          rg;
    logic [15:0] val;
    logic        zero;
  } exp_t;

  logic [15:0] mem [16];
  exp_t        sb[$];
  exp_t        head;
  logic        zeroModel = 1'b0;
  int          cycle = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clock) cycle++;

  // Register file: read data appears the cycle after the read strobe.
  always @(posedge clock) begin
    if (rf_ce) begin
      if (rf_we) mem[rf_addr] = rf_wdata;
      else       rf_rdata <= mem[rf_addr];
    end
  end

  always_comb begin
    alu_result = 16'h0000;
    case (alu_op)
      6'b001000: alu_result = alu_a + alu_b;
      6'b010000: alu_result = alu_a - alu_b;
      6'b100000: alu_result = alu_a ^ alu_b;
      6'b000010: alu_result = alu_a | alu_b;
      6'b000100: alu_result = alu_a & alu_b;
      6'b000001: alu_result = ~alu_a;
      default:   alu_result = 16'h0000;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Retirement monitor: busy-ready and illegal-no-strobe checks, then pops on done.
  always @(negedge clock) begin
    if (reset_n) begin
      if (sb.size() > 0 && sb[0].acc < cycle) begin
        checkOutput("ready_busy", {31'd0, instr_ready}, 32'd0);
        if (sb[0].ill) checkOutput("illegal_no_ce", {31'd0, rf_ce}, 32'd0);
      end
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_done", {31'd0, done}, 32'd0);
        end else begin
          head = sb.pop_front();
          checkOutput("latency", cycle - head.acc, head.lat);
          checkOutput("illegal", {31'd0, illegal}, {31'd0, head.ill});
          checkOutput("reg_value", {16'd0, mem[head.rg]}, {16'd0, head.val});
`ifdef SEQ_ZERO_FLAG_EN
          checkOutput("zero_flag", {31'd0, zero_flag}, {31'd0, head.zero});
`endif
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] opc, input int a1, input logic [15:0] a2,
                               input logic hold, output int accCycle);
    exp_t        e;
    logic [15:0] va, vb;
    bit          got;
    @(posedge clock);
    #1;
    instructie  = opc;
    argument1   = 16'(a1);
    argument2   = a2;
    instr_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      if (instr_ready) got = 1;
    end
    accCycle = cycle;
    if (!got) begin
      checkOutput("accept_timeout", {31'd0, instr_ready}, 32'd1);
      instr_valid = 1'b0;
      return;
    end
    va = mem[a1];
    vb = (opc == 8'h21 || opc == 8'h22) ? a2 : mem[a2[3:0]];
    e.ill = 1'b0;
    e.lat = 7;
    e.acc = accCycle;
    e.rg  = a1;
    case (opc)
      8'h01: e.val = va + vb;
      8'h02: e.val = va - vb;
      8'h03: e.val = va ^ vb;
      8'h04: e.val = va | vb;
      8'h05: e.val = va & vb;
      8'h21: begin e.val = va + vb; e.lat = 5; end
      8'h22: begin e.val = va - vb; e.lat = 5; end
      8'h06: begin e.val = ~va;     e.lat = 5; end
      default: begin e.val = va; e.lat = 1; e.ill = 1'b1; end
    endcase
    if (!e.ill) zeroModel = (e.val == 16'h0000);
    e.zero = zeroModel;
    sb.push_back(e);
    if (!hold) begin
      @(posedge clock);
      #1;
      instr_valid = 1'b0;
    end
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clock);
    if (sb.size() > 0) checkOutput("drain_timeout", sb.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int accA, accB, accX;
    bit sawWrite;
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    instructie  = 8'h00;
    argument1   = 16'h0000;
    argument2   = 16'h0000;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[1]  = 16'h0005; mem[2]  = 16'h0003; mem[3]  = 16'h0000; mem[4]  = 16'hA5A5;
    mem[5]  = 16'h0F0F; mem[6]  = 16'hFFFF; mem[7]  = 16'hF0F0; mem[8]  = 16'h3C3C;
    mem[9]  = 16'h1234; mem[10] = 16'h0F00; mem[11] = 16'h1111; mem[12] = 16'h2222;

    #12;
    checkOutput("rst_ready",   {31'd0, instr_ready}, 32'd1);
    checkOutput("rst_done",    {31'd0, done}, 32'd0);
    checkOutput("rst_illegal", {31'd0, illegal}, 32'd0);
    checkOutput("rst_rf_ce",   {31'd0, rf_ce}, 32'd0);
    checkOutput("rst_rf_we",   {31'd0, rf_we}, 32'd0);
    checkOutput("rst_rf_addr", {28'd0, rf_addr}, 32'd0);
    checkOutput("rst_wdata",   {16'd0, rf_wdata}, 32'd0);
    checkOutput("rst_alu_a",   {16'd0, alu_a}, 32'd0);
    checkOutput("rst_alu_b",   {16'd0, alu_b}, 32'd0);
    checkOutput("rst_alu_op",  {26'd0, alu_op}, 32'd0);
`ifdef SEQ_ZERO_FLAG_EN
    checkOutput("rst_zero",    {31'd0, zero_flag}, 32'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;

    applyStimulus(8'h01, 1, 16'h0002, 1'b0, accX); waitIdle();
    applyStimulus(8'h22, 3, 16'h0001, 1'b0, accX); waitIdle();
    applyStimulus(8'h03, 4, 16'h0004, 1'b0, accX); waitIdle();
    applyStimulus(8'h7F, 1, 16'h0002, 1'b0, accX); waitIdle();
    applyStimulus(8'h06, 5, 16'hBEEF, 1'b0, accX); waitIdle();
    applyStimulus(8'h21, 6, 16'h0002, 1'b0, accX); waitIdle();

    applyStimulus(8'h05, 7, 16'h0008, 1'b1, accA);
    applyStimulus(8'h04, 9, 16'h000A, 1'b0, accB);
    checkOutput("b2b_gap", accB - accA, 32'd8);
    waitIdle();

    applyStimulus(8'h01, 11, 16'h000C, 1'b0, accX);
    sawWrite = 0;
    for (int i = 0; i < 20 && !sawWrite; i++) begin
      @(negedge clock);
      if (rf_we) sawWrite = 1;
    end
    checkOutput("write_seen", {31'd0, rf_we}, 32'd1);
    reset_n = 1'b0;
    sb.delete();
    zeroModel = 1'b0;
    #1;
    checkOutput("abort_rf_ce", {31'd0, rf_ce}, 32'd0);
    checkOutput("abort_rf_we", {31'd0, rf_we}, 32'd0);
    checkOutput("abort_ready", {31'd0, instr_ready}, 32'd1);
    checkOutput("abort_done",  {31'd0, done}, 32'd0);
`ifdef SEQ_ZERO_FLAG_EN
    checkOutput("abort_zero",  {31'd0, zero_flag}, {31'd0, zeroModel});
`endif
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("abort_no_write", {16'd0, mem[11]}, 32'h1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
